// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - burst operand fetcher with local memory and 2-entry output buffer
//
// Reads count operands from an internal DEPTH x WIDTH memory starting at
// base_addr and streams them out with a valid/ready handshake.
//
// Build option: FETCH_WRAP_EN
//   defined   - burst addresses wrap modulo DEPTH, err is tied low
//   undefined - a burst running past the top of memory is rejected with err
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   wr_en/addr/data - memory load port
//   start          - burst request (IDLE only), with base_addr and count
//   out_valid/ready - downstream handshake
//   out_b          - operand, out_a its odd parity, out_last final operand
//   busy           - burst in progress (FETCH or DRAIN)
//   done           - one-cycle pulse when a burst completes
//   err            - one-cycle pulse when a start is rejected
module operand_fetch #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW:0]        remaining_q, remaining_d;

  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic [WIDTH-1:0]   obuf_data_q [2];
  logic               obuf_last_q [2];
  logic [1:0]         occ_q;
  logic               wptr_q;
  logic               rptr_q;

  logic               pop;
  logic               issue;
  logic               start_reject;
  logic               start_accept;

  // The read result lands straight in the buffer at the next edge, so a slot
  // is free for it whenever the buffer is not full or the head leaves now.
  assign pop   = (occ_q != 2'd0) && out_ready;
  assign issue = (state_q == S_FETCH) && ((occ_q != 2'd2) || pop);

`ifdef FETCH_WRAP_EN
  assign start_reject = 1'b0;
  assign err          = 1'b0;
`else
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  logic [AW:0] end_addr;
  logic        err_q;

  assign end_addr     = {1'b0, base_addr} + count;
  assign start_reject = (state_q == S_IDLE) && start && (end_addr > DEPTH_L);
  assign err          = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= start_reject;
    end
  end
`endif

  assign start_accept = (state_q == S_IDLE) && start && !start_reject &&
                        (count != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-length start goes straight to DONE so done
  // still pulses the following cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !start_reject) begin
          state_d = (count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue && (remaining_q == (AW+1)'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && obuf_last_q[rptr_q]) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (occ_q != 2'd0);
    out_b     = out_valid ? obuf_data_q[rptr_q] : '0;
    out_a     = ^out_b;
    out_last  = out_valid && obuf_last_q[rptr_q];
    busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
  end

  // Address / remaining-count
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    if (start_accept) begin
      addr_d      = base_addr;
      remaining_d = count;
    end else if (issue) begin
      addr_d      = addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  // Memory write port; the read below samples the pre-write value on a
  // same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Output buffer, filled by the synchronous memory read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        obuf_data_q[i] <= '0;
        obuf_last_q[i] <= 1'b0;
      end
      occ_q  <= 2'd0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      if (issue) begin
        obuf_data_q[wptr_q] <= mem_q[addr_q];
        obuf_last_q[wptr_q] <= (remaining_q == (AW+1)'(1));
        wptr_q              <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      occ_q <= occ_q + {1'b0, issue} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        out_valid;
  logic        out_ready;
  logic        out_a;
  logic [3:0]  out_b;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [3:0] got_b[$];
  logic       got_last[$];
  int         ndone;
  logic       timed_out;
  logic       err_seen;

  operand_fetch dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .base_addr(base_addr), .count(count),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [9:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic kick(input logic [9:0] b, input logic [10:0] c);
    start = 1'b1; base_addr = b; count = c;
    tick();
    start = 1'b0;
  endtask

  // Samples transfers each cycle until done (returns in the done cycle).
  task automatic collect(input int limit);
    got_b.delete(); got_last.delete();
    ndone = 0; timed_out = 1'b1; err_seen = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (err) err_seen = 1'b1;
      if (out_valid && out_ready) begin
        got_b.push_back(out_b);
        got_last.push_back(out_last);
      end
      if (done) begin
        ndone++;
        timed_out = 1'b0;
        break;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base_addr = 10'd5; count = 11'd3;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    checks++; if ({out_valid, out_a, out_b, out_last, busy, done, err} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {out_valid, out_a, out_b, out_last, busy, done, err});
    end
    tick();
    checks++; if ({out_valid, busy, done} !== 3'b0) begin
      errors++; $display("FAIL reset_idle got=%b exp=000", {out_valid, busy, done});
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_b [4] = '{4'd1, 4'd2, 4'd3, 4'd7};
    logic       exp_a [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    write_mem(10'd0, 4'd1); write_mem(10'd1, 4'd2);
    write_mem(10'd2, 4'd3); write_mem(10'd3, 4'd7);
    out_ready = 1'b1;
    kick(10'd0, 11'd4);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_cycle1 valid=%b busy=%b exp valid=0 busy=1", out_valid, busy);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_b !== exp_b[i]) begin
        errors++; $display("FAIL basic_data[%0d] valid=%b b=%0h exp valid=1 b=%0h", i, out_valid, out_b, exp_b[i]);
      end
      checks++; if (out_a !== exp_a[i]) begin
        errors++; $display("FAIL basic_parity[%0d] got=%b exp=%b", i, out_a, exp_a[i]);
      end
      checks++; if (out_last !== (i == 3)) begin
        errors++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, out_last, (i == 3));
      end
      checks++; if (done !== 1'b0) begin
        errors++; $display("FAIL basic_early_done[%0d] got=%b exp=0", i, done);
      end
      tick();
    end
    checks++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done done=%b valid=%b busy=%b exp 1 0 0", done, out_valid, busy);
    end
    tick();
    checks++; if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_b [4] = '{4'd1, 4'd2, 4'd3, 4'd7};
    logic       pat [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       held = 1'b0;
    logic [3:0] held_b = '0;
    logic       held_last = 1'b0;
    int         k = 0;
    int         nd = 0;
    kick(10'd0, 11'd4);
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = pat[cyc % 4];
      if (held) begin
        checks++; if (out_valid !== 1'b1 || out_b !== held_b || out_last !== held_last) begin
          errors++; $display("FAIL stall_hold valid=%b b=%0h last=%b exp 1 %0h %b", out_valid, out_b, out_last, held_b, held_last);
        end
      end
      if (out_valid) begin
        checks++; if (k > 3 || out_b !== exp_b[k & 3] || out_last !== (k == 3)) begin
          errors++; $display("FAIL stall_data[%0d] b=%0h last=%b exp %0h %b", k, out_b, out_last, exp_b[k & 3], (k == 3));
        end
      end
      held = out_valid && !out_ready;
      held_b = out_b;
      held_last = out_last;
      if (out_valid && out_ready) k++;
      if (done) begin
        nd++;
        break;
      end
      tick();
    end
    checks++; if (k !== 4 || nd !== 1) begin
      errors++; $display("FAIL stall_count transfers=%0d done=%0d exp 4 1", k, nd);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_bounds();
    logic quiet = 1'b1;
    write_mem(10'd1020, 4'd9); write_mem(10'd1021, 4'ha);
    write_mem(10'd1022, 4'd5); write_mem(10'd1023, 4'd6);
    out_ready = 1'b1;
`ifdef FETCH_WRAP_EN
    kick(10'd1022, 11'd4);
    collect(30);
    checks++; if (timed_out || got_b.size() !== 4 || err_seen) begin
      errors++; $display("FAIL wrap_burst size=%0d timeout=%b err=%b exp 4 0 0", got_b.size(), timed_out, err_seen);
    end else begin
      checks++; if (got_b[0] !== 4'd5 || got_b[1] !== 4'd6 || got_b[2] !== 4'd1 || got_b[3] !== 4'd2 || got_last[3] !== 1'b1) begin
        errors++; $display("FAIL wrap_data got=%0h%0h%0h%0h exp=5612", got_b[0], got_b[1], got_b[2], got_b[3]);
      end
    end
`else
    kick(10'd1022, 11'd4);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reject_err err=%b busy=%b exp 1 0", err, busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid || done || busy || err) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin
      errors++; $display("FAIL reject_quiet got=%b exp=1", quiet);
    end
`endif
    tick();
    kick(10'd1020, 11'd4);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL edge_accept err=%b busy=%b exp 0 1", err, busy);
    end
    collect(30);
    checks++; if (timed_out || got_b.size() !== 4) begin
      errors++; $display("FAIL edge_burst size=%0d timeout=%b exp 4 0", got_b.size(), timed_out);
    end else begin
      checks++; if (got_b[0] !== 4'd9 || got_b[1] !== 4'ha || got_b[2] !== 4'd5 || got_b[3] !== 4'd6) begin
        errors++; $display("FAIL edge_data got=%0h%0h%0h%0h exp=9a56", got_b[0], got_b[1], got_b[2], got_b[3]);
      end
    end
    tick();
  endtask

  task automatic test_zero_and_ignore();
    logic quiet = 1'b1;
    out_ready = 1'b1;
    kick(10'd0, 11'd0);
    checks++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done done=%b valid=%b busy=%b exp 1 0 0", done, out_valid, busy);
    end
    tick();
    checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_after done=%b valid=%b exp 0 0", done, out_valid);
    end
    kick(10'd0, 11'd4);
    start = 1'b1; base_addr = 10'd2; count = 11'd2;
    collect(30);
    checks++; if (timed_out || got_b.size() !== 4) begin
      errors++; $display("FAIL ignore_size size=%0d timeout=%b exp 4 0", got_b.size(), timed_out);
    end else begin
      checks++; if (got_b[0] !== 4'd1 || got_b[1] !== 4'd2 || got_b[2] !== 4'd3 || got_b[3] !== 4'd7) begin
        errors++; $display("FAIL ignore_data got=%0h%0h%0h%0h exp=1237", got_b[0], got_b[1], got_b[2], got_b[3]);
      end
    end
    start = 1'b1; base_addr = 10'd0; count = 11'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy || out_valid || done) quiet = 1'b0;
      tick();
    end
    checks++; if (quiet !== 1'b1) begin
      errors++; $display("FAIL ignore_in_done got=%b exp=1", quiet);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet = 1'b1;
    out_ready = 1'b1;
    kick(10'd0, 11'd4);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({out_valid, out_a, out_b, out_last, busy, done, err} !== 10'b0) begin
      errors++; $display("FAIL midreset_outputs got=%b exp=0", {out_valid, out_a, out_b, out_last, busy, done, err});
    end
    for (int i = 0; i < 5; i++) begin
      if (busy || out_valid || done) quiet = 1'b0;
      tick();
    end
    checks++; if (quiet !== 1'b1) begin
      errors++; $display("FAIL midreset_no_done got=%b exp=1", quiet);
    end
    kick(10'd1, 11'd2);
    collect(30);
    checks++; if (timed_out || got_b.size() !== 2) begin
      errors++; $display("FAIL postreset_size size=%0d timeout=%b exp 2 0", got_b.size(), timed_out);
    end else begin
      checks++; if (got_b[0] !== 4'd2 || got_b[1] !== 4'd3 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
        errors++; $display("FAIL postreset_data got=%0h%0h last=%b%b exp=23 01", got_b[0], got_b[1], got_last[0], got_last[1]);
      end
    end
    tick();
  endtask

  task automatic test_write_during_burst();
    out_ready = 1'b1;
    kick(10'd0, 11'd1);
    wr_en = 1'b1; wr_addr = 10'd0; wr_data = 4'hf;
    collect(30);
    checks++; if (timed_out || got_b.size() !== 1 || got_b[0] !== 4'd1) begin
      errors++; $display("FAIL collision_old size=%0d b=%0h exp 1 1", got_b.size(), (got_b.size() > 0) ? got_b[0] : 4'hx);
    end
    tick();
    kick(10'd0, 11'd4);
    wr_en = 1'b1; wr_addr = 10'd3; wr_data = 4'hc;
    collect(30);
    checks++; if (timed_out || got_b.size() !== 4) begin
      errors++; $display("FAIL late_write_size size=%0d timeout=%b exp 4 0", got_b.size(), timed_out);
    end else begin
      checks++; if (got_b[0] !== 4'hf || got_b[1] !== 4'd2 || got_b[2] !== 4'd3 || got_b[3] !== 4'hc) begin
        errors++; $display("FAIL late_write_data got=%0h%0h%0h%0h exp=f23c", got_b[0], got_b[1], got_b[2], got_b[3]);
      end
    end
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_stall();
    test_bounds();
    test_zero_and_ignore();
    test_reset_mid();
    test_write_during_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DEPTH, 1024, number of operand memory entries (address width 10).
REQ-002 Parameter WIDTH, 4, operand width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  load-port write strobe.
REQ-006 wr_addr  input  10  load-port address.
REQ-007 wr_data  input  WIDTH  load-port data.
REQ-008 start  input  1  begin a burst; sampled only in IDLE.
REQ-009 base_addr  input  10  first address of burst, sampled with start.
REQ-010 count  input  11  burst length 0..1024, sampled with start.
REQ-011 out_valid  output  1  downstream operand valid.
REQ-012 out_ready  input  1  downstream accepts operand.
REQ-013 out_a  output  1  odd parity of out_b (1 when out_b has an odd number of ones).
REQ-014 out_b  output  WIDTH  operand read from memory.
REQ-015 out_last  output  1  marks final operand of burst.
REQ-016 busy  output  1  high in FETCH and DRAIN.
REQ-017 done  output  1  one-cycle pulse at burst completion.
REQ-018 err  output  1  one-cycle pulse on rejected start.

Function
REQ-019 Internal DEPTH x WIDTH memory: synchronous write, synchronous read, 1-cycle read latency, read-before-write on same-address collision.
REQ-020 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on accepted start; FETCH->DRAIN when last read issued; DRAIN->DONE on last transfer; DONE->IDLE after one cycle.
REQ-021 Transfer occurs only on a cycle with out_valid=1 and out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, out_a, out_b, out_last are held stable.
REQ-023 A 2-entry output buffer absorbs read latency; a read is issued only when a buffer slot is guaranteed free, so no operand is dropped or duplicated.
REQ-024 First out_valid rises two cycles after the start cycle; with out_ready held high, one operand transfers per cycle thereafter.
REQ-025 Operands are emitted in address order base_addr, base_addr+1, ...
REQ-026 out_last=1 only on the count-th operand; done pulses the cycle after that operand transfers.
REQ-027 start with count=0 is a no-op: no out_valid; done pulses the following cycle.
REQ-028 start while busy or in DONE is ignored.
REQ-029 Writes to a not-yet-read address within the active burst are returned by the burst.
REQ-030 err is 0 whenever FETCH_WRAP_EN is defined.

Reset
REQ-031 rst=1 at a clock edge forces IDLE, empties the output buffer, clears the address and remaining-count registers.
REQ-032 Reset values: out_valid=0, out_a=0, out_b=0, out_last=0, busy=0, done=0, err=0.
REQ-033 Memory contents are not reset; rst asserted mid-burst aborts it without done.

Configuration
REQ-034 Macro FETCH_WRAP_EN defined: address increments modulo 1024, so base_addr+count>1024 wraps to 0.
REQ-035 Macro FETCH_WRAP_EN undefined: start with base_addr+count>1024 is rejected, err pulses the next cycle, FSM stays IDLE.

Verification
REQ-036 Load mem[0..3]=1,2,3,7; start base=0 count=4, out_ready=1 -> out_b 1,2,3,7 on four consecutive cycles, out_a 1,1,0,1, out_last on 7, done one cycle later.
REQ-037 Same burst with out_ready toggling 1,0,0,1,... -> identical sequence, no loss or duplicate, data stable while stalled.
REQ-038 start base=1022 count=4 -> with FETCH_WRAP_EN addresses 1022,1023,0,1 emitted; without it err pulse, no out_valid.
REQ-039 start count=0 -> done pulse next cycle, out_valid stays 0; second start during active burst -> ignored.
REQ-040 rst asserted after second transfer of a 4-operand burst -> next cycle all outputs 0, IDLE; new burst then runs correctly.
